// File: rtl/kw_bank_select_pipe.sv
// Registered kernel-weight bank selector: one of NUM_BANKS ROM words onto a valid/ready stream.
// Latency 1 cycle; select changes wait in DRAIN until the held beat has left.
module kw_bank_select_pipe #(
   parameter int DATA_W    = 384,
   parameter int NUM_BANKS = 8,
   parameter int SEL_W     = 3,
   parameter int CNT_W     = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_BANKS*DATA_W-1:0] bank_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [SEL_W-1:0]            sel_req,
   input  logic                        sel_load,
   output logic [DATA_W-1:0]           kw_out,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [SEL_W-1:0]            sel_active,
   output logic                        switching,
   output logic                        sel_err,
   output logic [CNT_W-1:0]            beat_cnt
);

   typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

   localparam logic [SEL_W:0] NB = (SEL_W+1)'(NUM_BANKS);

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   pending_q, pending_d;
   logic [SEL_W-1:0]   sel_active_q, sel_active_d;
   logic [DATA_W-1:0]  kw_q, kw_d;
   logic               vld_q, vld_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [DATA_W-1:0]  bank_word;
   logic               sel_ok;
   logic               xfer_in;
   logic               xfer_out;
   logic               apply;

   // Compare-based select keeps non-power-of-2 bank counts safe from out-of-range slicing.
   always_comb begin
      bank_word = '0;
      for (int k = 0; k < NUM_BANKS; k++) begin
         if (sel_active_q == SEL_W'(k)) bank_word = bank_data[k*DATA_W +: DATA_W];
      end
   end

   assign in_ready = (state_q == RUN) && (!vld_q || out_ready);
   assign xfer_in  = in_valid && in_ready;
   assign xfer_out = vld_q && out_ready;
   assign sel_ok   = sel_load && ({1'b0, sel_req} < NB);

   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      sel_active_d = sel_active_q;
      apply        = 1'b0;
      case (state_q)
         RUN: begin
            if (sel_ok) begin
               state_d   = DRAIN;
               pending_d = sel_req;
            end
         end
         DRAIN: begin
            if (sel_ok) pending_d = sel_req;
            if (!vld_q || xfer_out) begin
               apply        = 1'b1;
               sel_active_d = pending_d;
               state_d      = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      kw_d  = kw_q;
      vld_d = vld_q;
      if (xfer_in) begin
         kw_d  = bank_word;
         vld_d = 1'b1;
      end else if (xfer_out) begin
         vld_d = 1'b0;
      end
      err_d = sel_load && !sel_ok;
      cnt_d = cnt_q;
      if (apply)                          cnt_d = '0;
      else if (xfer_out && cnt_q != '1)   cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         pending_q    <= '0;
         sel_active_q <= '0;
         kw_q         <= '0;
         vld_q        <= 1'b0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         sel_active_q <= sel_active_d;
         kw_q         <= kw_d;
         vld_q        <= vld_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
      end
   end

   assign kw_out     = kw_q;
   assign out_valid  = vld_q;
   assign sel_active = sel_active_q;
   assign switching  = (state_q == DRAIN);
   assign sel_err    = err_q;
   assign beat_cnt   = cnt_q;

endmodule

// File: tb/tb_kw_bank_select_pipe.sv
// Bench for kw_bank_select_pipe: an 8-bank/16-bit-count instance and a 6-bank/4-bit-count instance share stimulus.
// A transaction-level model tracks what each instance should be showing after every clock.
module tb_kw_bank_select_pipe;

   localparam int DW = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, in_valid, out_ready, sel_load;
   logic [2:0]    sel_req;
   logic [DW-1:0] banks [8];
   logic [8*DW-1:0] bus_a;
   logic [6*DW-1:0] bus_b;

   always_comb begin
      for (int k = 0; k < 8; k++) bus_a[k*DW +: DW] = banks[k];
      for (int k = 0; k < 6; k++) bus_b[k*DW +: DW] = banks[k];
   end

   logic          a_rdy, a_vld, a_sw, a_err, b_rdy, b_vld, b_sw, b_err;
   logic [DW-1:0] a_kw, b_kw;
   logic [2:0]    a_sel, b_sel;
   logic [15:0]   a_cnt;
   logic [3:0]    b_cnt;

   kw_bank_select_pipe #(.DATA_W(DW), .NUM_BANKS(8), .SEL_W(3), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .bank_data(bus_a), .in_valid(in_valid), .in_ready(a_rdy),
      .sel_req(sel_req), .sel_load(sel_load), .kw_out(a_kw), .out_valid(a_vld),
      .out_ready(out_ready), .sel_active(a_sel), .switching(a_sw), .sel_err(a_err), .beat_cnt(a_cnt));

   kw_bank_select_pipe #(.DATA_W(DW), .NUM_BANKS(6), .SEL_W(3), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .bank_data(bus_b), .in_valid(in_valid), .in_ready(b_rdy),
      .sel_req(sel_req), .sel_load(sel_load), .kw_out(b_kw), .out_valid(b_vld),
      .out_ready(out_ready), .sel_active(b_sel), .switching(b_sw), .sel_err(b_err), .beat_cnt(b_cnt));

   int checks = 0;
   int failures = 0;

   // Model index 0 follows dut_a, index 1 follows dut_b.
   int            nb   [2] = '{8, 6};
   int            cmax [2] = '{65535, 15};
   bit            m_drain [2];
   bit            m_vld   [2];
   bit            m_err   [2];
   int            m_act   [2];
   int            m_pend  [2];
   int            m_cnt   [2];
   logic [DW-1:0] m_kw    [2];

   function automatic bit m_rdy(int m);
      return !m_drain[m] && (!m_vld[m] || out_ready);
   endfunction

   task automatic tick();
      bit            n_drain [2];
      bit            n_vld   [2];
      bit            n_err   [2];
      int            n_act   [2];
      int            n_pend  [2];
      int            n_cnt   [2];
      logic [DW-1:0] n_kw    [2];
      for (int m = 0; m < 2; m++) begin
         bit accept, deliver, ok, done;
         accept    = in_valid && m_rdy(m);
         deliver   = m_vld[m] && out_ready;
         ok        = sel_load && (int'(sel_req) < nb[m]);
         done      = m_drain[m] && (!m_vld[m] || deliver);
         n_pend[m] = ok ? int'(sel_req) : m_pend[m];
         n_err[m]  = sel_load && !ok;
         n_kw[m]   = accept ? banks[m_act[m]] : m_kw[m];
         n_vld[m]  = accept ? 1'b1 : (deliver ? 1'b0 : m_vld[m]);
         n_cnt[m]  = done ? 0 : ((deliver && m_cnt[m] < cmax[m]) ? m_cnt[m] + 1 : m_cnt[m]);
         n_act[m]  = done ? n_pend[m] : m_act[m];
         n_drain[m] = done ? 1'b0 : (m_drain[m] || ok);
         if (rst) begin
            n_pend[m] = 0; n_err[m] = 0; n_kw[m] = '0; n_vld[m] = 0;
            n_cnt[m] = 0; n_act[m] = 0; n_drain[m] = 0;
         end
      end
      @(posedge clk);
      m_drain = n_drain; m_vld = n_vld; m_err = n_err; m_act = n_act;
      m_pend = n_pend; m_cnt = n_cnt; m_kw = n_kw;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel_load = 1'b0; sel_req = '0;
      for (int k = 0; k < 8; k++) banks[k] = {4{16'(k * 16)}};
      tick(); tick();
      checks++; if (a_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%b exp=0", a_vld); end
      checks++; if (a_kw !== '0) begin failures++; $display("FAIL reset_kw got=%h exp=0", a_kw); end
      checks++; if (a_sel !== 3'd0 || a_sw !== 1'b0 || a_err !== 1'b0) begin failures++; $display("FAIL reset_sel got sel=%0d sw=%b err=%b exp 0/0/0", a_sel, a_sw, a_err); end
      checks++; if (a_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", a_cnt); end
      checks++; if (a_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b exp=1", a_rdy); end
      rst = 1'b0;
   endtask

   task automatic test_stream();
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         checks++; if (a_vld !== 1'b1 || a_kw !== banks[0]) begin failures++; $display("FAIL stream_beat%0d got vld=%b kw=%h exp vld=1 kw=%h", i, a_vld, a_kw, banks[0]); end
         checks++; if (a_cnt !== 16'(i - 1) || a_cnt !== 16'(m_cnt[0])) begin failures++; $display("FAIL stream_cnt%0d got=%0d exp=%0d", i, a_cnt, i - 1); end
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] held_kw;
      logic [15:0]   held_cnt;
      held_kw = a_kw; held_cnt = a_cnt;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (a_rdy !== 1'b0 || a_vld !== 1'b1) begin failures++; $display("FAIL bp_stall%0d got rdy=%b vld=%b exp rdy=0 vld=1", i, a_rdy, a_vld); end
         checks++; if (a_kw !== held_kw || a_cnt !== held_cnt) begin failures++; $display("FAIL bp_hold%0d got kw=%h cnt=%0d exp kw=%h cnt=%0d", i, a_kw, a_cnt, held_kw, held_cnt); end
      end
      out_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++; if (a_cnt !== held_cnt + 16'(i) || a_vld !== 1'b1) begin failures++; $display("FAIL bp_resume%0d got cnt=%0d vld=%b exp cnt=%0d vld=1", i, a_cnt, a_vld, held_cnt + 16'(i)); end
      end
   endtask

   task automatic test_switch();
      out_ready = 1'b0; sel_load = 1'b1; sel_req = 3'd5;
      tick();
      sel_load = 1'b0;
      checks++; if (a_sw !== 1'b1 || a_sel !== 3'd0) begin failures++; $display("FAIL switch_enter got sw=%b sel=%0d exp sw=1 sel=0", a_sw, a_sel); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (a_sw !== 1'b1 || a_rdy !== 1'b0) begin failures++; $display("FAIL switch_drain%0d got sw=%b rdy=%b exp sw=1 rdy=0", i, a_sw, a_rdy); end
      end
      out_ready = 1'b1;
      tick();
      checks++; if (a_sw !== 1'b0 || a_sel !== 3'd5 || a_cnt !== 16'd0) begin failures++; $display("FAIL switch_apply got sw=%b sel=%0d cnt=%0d exp sw=0 sel=5 cnt=0", a_sw, a_sel, a_cnt); end
      tick();
      checks++; if (a_vld !== 1'b1 || a_kw !== banks[5]) begin failures++; $display("FAIL switch_newbank got vld=%b kw=%h exp vld=1 kw=%h", a_vld, a_kw, banks[5]); end
   endtask

   task automatic test_last_wins();
      out_ready = 1'b0; sel_load = 1'b1; sel_req = 3'd3;
      tick();
      sel_req = 3'd6;
      tick();
      sel_load = 1'b0;
      checks++; if (a_sel !== 3'd5 || a_sw !== 1'b1) begin failures++; $display("FAIL lastwin_drain got sel=%0d sw=%b exp sel=5 sw=1", a_sel, a_sw); end
      out_ready = 1'b1;
      tick();
      checks++; if (a_sel !== 3'd6) begin failures++; $display("FAIL lastwin_apply got=%0d exp=6", a_sel); end
      checks++; if (b_sel !== 3'(m_act[1]) || b_sel !== 3'd3) begin failures++; $display("FAIL lastwin_b got=%0d exp=3", b_sel); end
      tick();
      checks++; if (a_kw !== banks[6]) begin failures++; $display("FAIL lastwin_kw got=%h exp=%h", a_kw, banks[6]); end
   endtask

   task automatic test_same_cycle_accept();
      tick();
      sel_load = 1'b1; sel_req = 3'd1;
      tick();
      sel_load = 1'b0;
      checks++; if (a_kw !== banks[6] || a_sw !== 1'b1) begin failures++; $display("FAIL samecyc_old got kw=%h sw=%b exp kw=%h sw=1", a_kw, a_sw, banks[6]); end
      tick(); tick();
      checks++; if (a_sel !== 3'd1 || a_kw !== banks[1]) begin failures++; $display("FAIL samecyc_new got sel=%0d kw=%h exp sel=1 kw=%h", a_sel, a_kw, banks[1]); end
   endtask

   task automatic test_bad_sel();
      logic [2:0] prev;
      for (int j = 0; j < 2; j++) begin
         tick();
         prev = b_sel;
         sel_load = 1'b1; sel_req = (j == 0) ? 3'd7 : 3'd6;
         tick();
         sel_load = 1'b0;
         checks++; if (b_err !== 1'b1 || b_sw !== 1'b0) begin failures++; $display("FAIL badsel%0d_pulse got err=%b sw=%b exp err=1 sw=0", j, b_err, b_sw); end
         checks++; if (b_sel !== prev || b_rdy !== 1'b1) begin failures++; $display("FAIL badsel%0d_state got sel=%0d rdy=%b exp sel=%0d rdy=1", j, b_sel, b_rdy, prev); end
         checks++; if (a_err !== 1'b0 || a_sw !== 1'b1) begin failures++; $display("FAIL badsel%0d_a got err=%b sw=%b exp err=0 sw=1", j, a_err, a_sw); end
         tick();
         checks++; if (b_err !== 1'b0) begin failures++; $display("FAIL badsel%0d_clear got=%b exp=0", j, b_err); end
      end
   endtask

   task automatic test_reset_drain();
      out_ready = 1'b0; in_valid = 1'b1; tick();
      sel_load = 1'b1; sel_req = 3'd2; tick();
      sel_load = 1'b0;
      checks++; if (a_sw !== 1'b1) begin failures++; $display("FAIL rstdrain_enter got=%b exp=1", a_sw); end
      rst = 1'b1; tick(); rst = 1'b0;
      checks++; if (a_sw !== 1'b0 || a_vld !== 1'b0 || a_sel !== 3'd0 || a_cnt !== 16'd0 || a_kw !== '0 || a_err !== 1'b0) begin failures++; $display("FAIL rstdrain_vals got sw=%b vld=%b sel=%0d cnt=%0d kw=%h err=%b exp all 0", a_sw, a_vld, a_sel, a_cnt, a_kw, a_err); end
      out_ready = 1'b1; tick(); tick();
      checks++; if (a_sel !== 3'd0 || a_kw !== banks[0] || a_sw !== 1'b0) begin failures++; $display("FAIL rstdrain_after got sel=%0d kw=%h sw=%b exp sel=0 kw=%h sw=0", a_sel, a_kw, a_sw, banks[0]); end
   endtask

   task automatic test_saturate();
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++; if (b_cnt !== 4'(m_cnt[1])) begin failures++; $display("FAIL sat_step%0d got=%0d exp=%0d", i, b_cnt, m_cnt[1]); end
      end
      checks++; if (b_cnt !== 4'd15) begin failures++; $display("FAIL sat_final got=%0d exp=15", b_cnt); end
      checks++; if (a_cnt !== 16'(m_cnt[0])) begin failures++; $display("FAIL sat_a got=%0d exp=%0d", a_cnt, m_cnt[0]); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         for (int k = 0; k < 8; k++) banks[k] = {$urandom, $urandom};
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         sel_load  = ($urandom_range(0, 7) == 0);
         sel_req   = 3'($urandom_range(0, 7));
         rst       = ($urandom_range(0, 199) == 0);
         tick();
         checks++; if (a_vld !== m_vld[0] || (m_vld[0] && a_kw !== m_kw[0])) begin failures++; $display("FAIL rand%0d_a_data got vld=%b kw=%h exp vld=%b kw=%h", i, a_vld, a_kw, m_vld[0], m_kw[0]); end
         checks++; if (a_sel !== 3'(m_act[0]) || a_sw !== m_drain[0] || a_err !== m_err[0] || a_cnt !== 16'(m_cnt[0])) begin failures++; $display("FAIL rand%0d_a_ctl got sel=%0d sw=%b err=%b cnt=%0d exp sel=%0d sw=%b err=%b cnt=%0d", i, a_sel, a_sw, a_err, a_cnt, m_act[0], m_drain[0], m_err[0], m_cnt[0]); end
         checks++; if (a_rdy !== m_rdy(0) || b_rdy !== m_rdy(1)) begin failures++; $display("FAIL rand%0d_rdy got a=%b b=%b exp a=%b b=%b", i, a_rdy, b_rdy, m_rdy(0), m_rdy(1)); end
         checks++; if (b_vld !== m_vld[1] || (m_vld[1] && b_kw !== m_kw[1])) begin failures++; $display("FAIL rand%0d_b_data got vld=%b kw=%h exp vld=%b kw=%h", i, b_vld, b_kw, m_vld[1], m_kw[1]); end
         checks++; if (b_sel !== 3'(m_act[1]) || b_sw !== m_drain[1] || b_err !== m_err[1] || b_cnt !== 4'(m_cnt[1])) begin failures++; $display("FAIL rand%0d_b_ctl got sel=%0d sw=%b err=%b cnt=%0d exp sel=%0d sw=%b err=%b cnt=%0d", i, b_sel, b_sw, b_err, b_cnt, m_act[1], m_drain[1], m_err[1], m_cnt[1]); end
      end
      rst = 1'b0; sel_load = 1'b0;
   endtask

   initial begin
      #1;
      test_reset();
      test_stream();
      test_backpressure();
      test_switch();
      test_last_wins();
      test_same_cycle_accept();
      test_bad_sel();
      test_reset_drain();
      test_saturate();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
